switch_box_config_loader: RTL and testbench
===========================================

SWITCH_BOX_CONFIG_LOADER -- requirements
Module: switch_box_config_loader

Interface
REQ-001 The block SHALL have parameter WS, default 8, meaning single-length track count per side.
REQ-002 The block SHALL have parameter WD, default 8, meaning double-length track count per side (multiple of 2).
REQ-003 The block SHALL derive CW = WS*6 + WD/2*6 (config vector width, 72 at defaults) and NW = ceil(CW/8) (beats per frame, 9 at defaults); neither is overridable.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 cfg_valid  input  1  upstream beat valid.
REQ-007 cfg_ready  output  1  loader can accept a beat.
REQ-008 cfg_data  input  8  config beat payload.
REQ-009 cfg_last  input  1  marks final beat of a frame.
REQ-010 c  output  CW  active switch-box configuration vector.
REQ-011 busy  output  1  frame in progress (state not IDLE).
REQ-012 cfg_done  output  1  one-cycle pulse: frame committed to c.
REQ-013 cfg_error  output  1  one-cycle pulse: frame rejected, c unchanged.

Function
REQ-014 A beat SHALL be accepted on a rising edge where cfg_valid and cfg_ready are both 1; no other edge changes the beat counter or shadow register.
REQ-015 States SHALL be IDLE, LOAD, DRAIN, COMMIT, REJECT; cfg_ready SHALL be 1 in IDLE, LOAD, DRAIN and 0 in COMMIT, REJECT.
REQ-016 Accepted beat k (0-based counter) SHALL be written to shadow bits [8k+7:8k]; bits at index >= CW in the final beat SHALL be discarded.
REQ-017 IDLE: accepted beat with cfg_last=0 -> LOAD (counter=1); with cfg_last=1 -> COMMIT if NW=1, else REJECT.
REQ-018 LOAD: accepted beat with cfg_last=1 -> COMMIT if counter = NW-1, else REJECT (short frame).
REQ-019 LOAD: accepted beat with cfg_last=0 and counter = NW-1 -> DRAIN (long frame); shadow SHALL NOT be written beyond beat NW-1.
REQ-020 DRAIN: beats SHALL be accepted and discarded; accepted beat with cfg_last=1 -> REJECT.
REQ-021 COMMIT: lasts exactly one cycle; on its exit edge c <= shadow, cfg_done <= 1, state -> IDLE, counter -> 0.
REQ-022 REJECT: lasts exactly one cycle; on its exit edge cfg_error <= 1, c unchanged, state -> IDLE, counter -> 0.
REQ-023 Latency: last beat accepted on edge E -> c and cfg_done update on edge E+1; cfg_done/cfg_error SHALL be high for exactly one cycle.
REQ-024 c SHALL change only on a COMMIT exit edge or reset; partial frames SHALL never be visible on c.
REQ-025 cfg_data and cfg_last SHALL be ignored whenever cfg_valid=0 or cfg_ready=0.
REQ-026 Shadow contents SHALL persist across frames; a committed frame fully overwrites bits [CW-1:0].
REQ-027 busy SHALL equal (state != IDLE), combinationally.

Reset
REQ-028 While rst=1: state=IDLE, counter=0, shadow=0, c=0 (all switches open), cfg_done=0, cfg_error=0, busy=0, cfg_ready=0.
REQ-029 Reset asserted mid-frame SHALL abandon the frame immediately with no cfg_done/cfg_error pulse; first beat after deassertion starts a new frame.
REQ-030 cfg_ready SHALL return to 1 in the first cycle after rst deasserts.

Verification
REQ-031 Reset then 9 back-to-back beats 0x01..0x09, last on beat 9 -> c = 0x090807060504030201, cfg_done high one cycle at E+1, busy low after.
REQ-032 Same frame with cfg_valid dropped for 3 cycles between beats 4 and 5 -> identical c, counter holds during gap.
REQ-033 Commit 0xFF x9, then short frame of 5 beats 0x00 with last on beat 5 -> cfg_error pulse, c stays all-ones (0xFF..FF).
REQ-034 11-beat frame, last on beat 11 -> DRAIN on beat 10, cfg_error after beat 11, c unchanged.
REQ-035 rst asserted after beat 4 of a frame -> c = 0, no pulses; following full 9-beat frame commits correctly.
REQ-036 WS=3, WD=2 (CW=24, NW=3): 3 beats 0xAA,0xBB,0xCC -> c = 0xCCBBAA; single beat with last=1 -> cfg_error.

Source files
------------

// File: rtl/switch_box_config_loader.sv
// Streams byte-wide configuration beats into a shadow register and commits the
// whole switch-box vector atomically once a correctly sized frame completes.
module switch_box_config_loader #(
  parameter  int WS = 8,
  parameter  int WD = 8,
  localparam int CW = WS*6 + (WD/2)*6,
  localparam int NW = (CW + 7) / 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [7:0]    cfg_data,
  input  logic          cfg_last,
  output logic [CW-1:0] c,
  output logic          busy,
  output logic          cfg_done,
  output logic          cfg_error
);

  localparam int CNT_W = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NW - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRAIN, S_COMMIT, S_REJECT} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CW-1:0]    r_shadow;
  logic [CW-1:0]    r_c;
  logic             r_done;
  logic             r_error;

  logic             w_acc;
  logic             w_wr;
  logic [NW-1:0]    w_beat_sel;
  logic [CW-1:0]    w_shadow_next;

  assign cfg_ready = !rst && (r_state == S_IDLE || r_state == S_LOAD || r_state == S_DRAIN);
  assign w_acc     = cfg_valid && cfg_ready;
  assign w_wr      = w_acc && (r_state == S_IDLE || r_state == S_LOAD);
  assign busy      = (r_state != S_IDLE);
  assign c         = r_c;
  assign cfg_done  = r_done;
  assign cfg_error = r_error;

  // Each beat owns one byte lane of the shadow; the top lane is clipped to CW.
  genvar gi;
  generate
    for (gi = 0; gi < NW; gi++) begin : g_lane
      localparam int LO = gi * 8;
      localparam int HI = (gi * 8 + 7 < CW) ? gi * 8 + 7 : CW - 1;
      assign w_beat_sel[gi] = (r_cnt == CNT_W'(gi));
      assign w_shadow_next[HI:LO] = (w_wr && w_beat_sel[gi]) ? cfg_data[HI-LO:0]
                                                              : r_shadow[HI:LO];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_shadow <= '0;
      r_c      <= '0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      r_done   <= 1'b0;
      r_error  <= 1'b0;
      r_shadow <= w_shadow_next;
      case (r_state)
        S_IDLE: begin
          if (w_acc) begin
            if (cfg_last) begin
              r_state <= (NW == 1) ? S_COMMIT : S_REJECT;
            end else if (NW == 1) begin
              r_state <= S_DRAIN;
            end else begin
              r_state <= S_LOAD;
              r_cnt   <= CNT_W'(1);
            end
          end
        end
        S_LOAD: begin
          if (w_acc) begin
            if (cfg_last) begin
              r_state <= (r_cnt == LAST_BEAT) ? S_COMMIT : S_REJECT;
            end else if (r_cnt == LAST_BEAT) begin
              r_state <= S_DRAIN;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        S_DRAIN: begin
          if (w_acc && cfg_last) r_state <= S_REJECT;
        end
        S_COMMIT: begin
          r_c     <= r_shadow;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
        S_REJECT: begin
          r_error <= 1'b1;
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_switch_box_config_loader.sv
// Self-checking bench: frame table, reset/corner sequences and a randomized run
// compared cycle by cycle against a frame-level reference model.
module tb_switch_box_config_loader;

  localparam int CW = 72;
  localparam int NW = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic          v, l;
  logic [7:0]    d;
  logic          cfg_ready, busy, cfg_done, cfg_error;
  logic [CW-1:0] c;

  logic          s_v, s_l;
  logic [7:0]    s_d;
  logic          s_ready, s_busy, s_done, s_error;
  logic [23:0]   s_c;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  switch_box_config_loader dut (
    .clk(clk), .rst(rst), .cfg_valid(v), .cfg_ready(cfg_ready), .cfg_data(d),
    .cfg_last(l), .c(c), .busy(busy), .cfg_done(cfg_done), .cfg_error(cfg_error)
  );

  switch_box_config_loader #(.WS(3), .WD(2)) dut_small (
    .clk(clk), .rst(rst), .cfg_valid(s_v), .cfg_ready(s_ready), .cfg_data(s_d),
    .cfg_last(s_l), .c(s_c), .busy(s_busy), .cfg_done(s_done), .cfg_error(s_error)
  );

  // Reference model: a frame is the list of accepted bytes; on its last byte it
  // is committed if it holds exactly NW bytes, otherwise rejected. The outcome
  // becomes visible one cycle later, during which no beat is taken.
  logic [7:0]    m_q[$];
  int            m_pend = 0;   // 0 none, 1 commit pending, 2 reject pending
  logic [CW-1:0] m_pc = '0;
  logic [CW-1:0] m_c = '0;
  logic          m_done = 1'b0;
  logic          m_err = 1'b0;
  bit            chk_en = 1'b0;

  function automatic logic m_ready();
    return !rst && (m_pend == 0);
  endfunction

  task automatic model_step();
    if (rst) begin
      m_q.delete();
      m_pend = 0;
      m_c = '0;
      m_done = 1'b0;
      m_err = 1'b0;
      return;
    end
    m_done = 1'b0;
    m_err = 1'b0;
    if (m_pend != 0) begin
      if (m_pend == 1) begin
        m_c = m_pc;
        m_done = 1'b1;
      end else begin
        m_err = 1'b1;
      end
      m_pend = 0;
    end else if (v) begin
      m_q.push_back(d);
      if (l) begin
        if (m_q.size() == NW) begin
          for (int i = 0; i < NW; i++) m_pc[i*8 +: 8] = m_q[i];
          m_pend = 1;
        end else begin
          m_pend = 2;
        end
        m_q.delete();
      end
    end
  endtask

  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    if (chk_en) begin
      chk("model_c", c, m_c);
      chk("model_done", cfg_done, m_done);
      chk("model_error", cfg_error, m_err);
      chk("model_ready", cfg_ready, m_ready());
      chk("model_busy", busy, (m_q.size() > 0) || (m_pend != 0));
    end
  endtask

  typedef struct {
    int            n;
    logic [7:0]    base;
    logic [7:0]    step;
    int            gap_at;
    int            gap_len;
    logic          exp_done;
    logic [CW-1:0] exp_c;
  } frame_t;

  frame_t tbl[7];

  int   bi, flen;
  logic acc;

  initial begin
    tbl[0] = '{9,  8'h01, 8'h01, 0, 0, 1'b1, 72'h090807060504030201};
    tbl[1] = '{9,  8'h01, 8'h01, 4, 3, 1'b1, 72'h090807060504030201};
    tbl[2] = '{9,  8'hFF, 8'h00, 0, 0, 1'b1, {9{8'hFF}}};
    tbl[3] = '{5,  8'h00, 8'h00, 0, 0, 1'b0, {9{8'hFF}}};
    tbl[4] = '{11, 8'h10, 8'h01, 0, 0, 1'b0, {9{8'hFF}}};
    tbl[5] = '{9,  8'hA0, 8'h01, 0, 0, 1'b1, 72'hA8A7A6A5A4A3A2A1A0};
    tbl[6] = '{1,  8'h55, 8'h00, 0, 0, 1'b0, 72'hA8A7A6A5A4A3A2A1A0};

    rst = 1'b0; v = 1'b0; l = 1'b0; d = 8'h00;
    s_v = 1'b0; s_l = 1'b0; s_d = 8'h00;
    #1 rst = 1'b1;
    #1;
    chk("rst_c", c, '0);
    chk("rst_ready", cfg_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", cfg_done, 1'b0);
    chk("rst_error", cfg_error, 1'b0);
    chk("rst_small_c", s_c, '0);
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("ready_after_rst", cfg_ready, 1'b1);
    chk("small_ready_after_rst", s_ready, 1'b1);
    chk_en = 1'b1;

    // Frame table
    foreach (tbl[f]) begin
      for (int i = 0; i < tbl[f].n; i++) begin
        if (tbl[f].gap_len > 0 && i == tbl[f].gap_at) begin
          v = 1'b0; l = 1'b1; d = 8'($urandom);
          repeat (tbl[f].gap_len) tick();
          chk("gap_busy", busy, 1'b1);
        end
        v = 1'b1;
        d = tbl[f].base + 8'(i) * tbl[f].step;
        l = (i == tbl[f].n - 1);
        tick();
      end
      chk("last_ready_low", cfg_ready, 1'b0);
      v = 1'b0; l = 1'b0; d = 8'($urandom);
      tick();
      chk("tbl_done", cfg_done, tbl[f].exp_done);
      chk("tbl_error", cfg_error, !tbl[f].exp_done);
      chk("tbl_c", c, tbl[f].exp_c);
      tick();
      chk("tbl_pulse_end", {cfg_done, cfg_error}, 2'b00);
      chk("tbl_idle", busy, 1'b0);
    end

    // Reset in the middle of a frame, then a fresh full frame
    for (int i = 0; i < 4; i++) begin
      v = 1'b1; d = 8'h30 + 8'(i); l = 1'b0;
      tick();
    end
    rst = 1'b1; v = 1'b0;
    #1;
    chk("midrst_c", c, '0);
    chk("midrst_ready", cfg_ready, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("midrst_ready_back", cfg_ready, 1'b1);
    for (int i = 0; i < NW; i++) begin
      v = 1'b1; d = 8'h40 + 8'(i); l = (i == NW - 1);
      tick();
    end
    v = 1'b0; l = 1'b0;
    tick();
    chk("midrst_commit_c", c, 72'h484746454443424140);
    chk("midrst_commit_done", cfg_done, 1'b1);
    tick();

    // Randomized traffic against the model
    bi = 0;
    flen = 9;
    for (int t = 0; t < 600; t++) begin
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b1; v = 1'b0;
        tick();
        rst = 1'b0;
        bi = 0;
        continue;
      end
      v = ($urandom_range(0, 9) < 7);
      d = 8'($urandom);
      if (v) l = (bi == flen - 1);
      else   l = 1'($urandom);
      acc = v && m_ready();
      tick();
      if (acc) begin
        if (l) begin
          bi = 0;
          flen = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 11)) : NW;
        end else begin
          bi++;
        end
      end
    end
    v = 1'b0; l = 1'b0;
    tick(); tick();

    // Reduced configuration: CW=24, NW=3
    s_v = 1'b1; s_d = 8'hAA; s_l = 1'b0; tick();
    s_d = 8'hBB; tick();
    s_d = 8'hCC; s_l = 1'b1; tick();
    chk("small_commit_state", {s_ready, s_busy}, 2'b01);
    s_v = 1'b0; s_l = 1'b0;
    tick();
    chk("small_c", s_c, 24'hCCBBAA);
    chk("small_done", s_done, 1'b1);
    tick();
    chk("small_done_end", s_done, 1'b0);
    s_v = 1'b1; s_d = 8'h11; s_l = 1'b1; tick();
    s_v = 1'b0; s_l = 1'b0;
    tick();
    chk("small_error", s_error, 1'b1);
    chk("small_c_kept", s_c, 24'hCCBBAA);
    tick();
    chk("small_error_end", s_error, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
